// File: rtl/exec_issue_reg_pkg.sv
// Shared Y86 constants and the execute-stage control bundle used by the issue register.
// Pure definitions: no logic and no latency.
package exec_issue_reg_pkg;

    localparam int DATA_WID = 32;

    // Instruction codes
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVL = 4'h2;
    localparam logic [3:0] I_IRMOVL = 4'h3;
    localparam logic [3:0] I_RMMOVL = 4'h4;
    localparam logic [3:0] I_MRMOVL = 4'h5;
    localparam logic [3:0] I_OPL    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHL  = 4'hA;
    localparam logic [3:0] I_POPL   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;

    // Pipeline status codes
    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    typedef struct packed {
        logic [2:0] stat;
        logic [3:0] icode;
        logic [3:0] ifun;
        logic [3:0] dst_e;
        logic [3:0] dst_m;
    } e_ctrl_t;

    function automatic e_ctrl_t bubble_ctrl();
        e_ctrl_t c;
        c.stat  = S_AOK;
        c.icode = I_NOP;
        c.ifun  = 4'h0;
        c.dst_e = RNONE;
        c.dst_m = RNONE;
        return c;
    endfunction

endpackage

// File: rtl/exec_issue_reg_hazard_detect.sv
// Load/use and branch-mispredict detection against the instruction now in execute.
// Latency: combinational. Backpressure: none, pure function of its inputs.
module exec_issue_reg_hazard_detect
    import exec_issue_reg_pkg::*;
(
    input  logic [3:0] e_icode_i,
    input  logic [3:0] e_dstm_i,
    input  logic       e_cond_i,
    input  logic [3:0] d_srca_i,
    input  logic [3:0] d_srcb_i,
    output logic       load_use_o,
    output logic       mispredict_o
);

    logic is_load;

    assign is_load = (e_icode_i == I_MRMOVL) || (e_icode_i == I_POPL);

    // RNONE on the load's destination means nothing is written, so no source can depend on it.
    assign load_use_o = is_load && (e_dstm_i != RNONE) &&
                        ((e_dstm_i == d_srca_i) || (e_dstm_i == d_srcb_i));

    assign mispredict_o = (e_icode_i == I_JXX) && !e_cond_i;

endmodule

// File: rtl/exec_issue_reg.sv
// Decode-to-execute pipeline register with load/use stall, mispredict squash and bubble counter.
// Latency: one cycle d_* -> e_*. Backpressure: ext_stall or a non-AOK e_stat holds the register.
module exec_issue_reg
    import exec_issue_reg_pkg::*;
#(
    parameter int DATA_WID = exec_issue_reg_pkg::DATA_WID,
    parameter int CNT_WID  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [2:0]          d_stat,
    input  logic [3:0]          d_icode,
    input  logic [3:0]          d_ifun,
    input  logic [DATA_WID-1:0] d_valA,
    input  logic [DATA_WID-1:0] d_valB,
    input  logic [DATA_WID-1:0] d_valC,
    input  logic [3:0]          d_dstE,
    input  logic [3:0]          d_dstM,
    input  logic [3:0]          d_srcA,
    input  logic [3:0]          d_srcB,
    input  logic                e_cond,
    input  logic                ext_stall,
    output logic [2:0]          e_stat,
    output logic [3:0]          e_icode,
    output logic [3:0]          e_ifun,
    output logic [DATA_WID-1:0] e_valA,
    output logic [DATA_WID-1:0] e_valB,
    output logic [DATA_WID-1:0] e_valC,
    output logic [3:0]          e_dstE,
    output logic [3:0]          e_dstM,
    output logic                stall_fd,
    output logic                squash_d,
    output logic [CNT_WID-1:0]  bubble_cnt
);

    e_ctrl_t             ctrl_q, ctrl_d;
    logic [DATA_WID-1:0] vala_q, vala_d;
    logic [DATA_WID-1:0] valb_q, valb_d;
    logic [DATA_WID-1:0] valc_q, valc_d;
    logic [CNT_WID-1:0]  cnt_q, cnt_d;

    logic load_use;
    logic mispredict;
    logic halted;
    logic hold;

    exec_issue_reg_hazard_detect u_hazard_detect (
        .e_icode_i    (ctrl_q.icode),
        .e_dstm_i     (ctrl_q.dst_m),
        .e_cond_i     (e_cond),
        .d_srca_i     (d_srcA),
        .d_srcb_i     (d_srcB),
        .load_use_o   (load_use),
        .mispredict_o (mispredict)
    );

    // A faulted instruction in execute freezes the pipe until reset.
    assign halted = (ctrl_q.stat != S_AOK);
    assign hold   = ext_stall || halted;

    always_comb begin
        ctrl_d = ctrl_q;
        vala_d = vala_q;
        valb_d = valb_q;
        valc_d = valc_q;
        cnt_d  = cnt_q;
        if (!hold) begin
            if (mispredict || load_use) begin
                ctrl_d = bubble_ctrl();
                vala_d = '0;
                valb_d = '0;
                valc_d = '0;
                if (cnt_q != {CNT_WID{1'b1}}) begin
                    cnt_d = cnt_q + CNT_WID'(1);
                end
            end else begin
                ctrl_d.stat  = d_stat;
                ctrl_d.icode = d_icode;
                ctrl_d.ifun  = d_ifun;
                ctrl_d.dst_e = d_dstE;
                ctrl_d.dst_m = d_dstM;
                vala_d       = d_valA;
                valb_d       = d_valB;
                valc_d       = d_valC;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_q <= bubble_ctrl();
            vala_q <= '0;
            valb_q <= '0;
            valc_q <= '0;
            cnt_q  <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            vala_q <= vala_d;
            valb_q <= valb_d;
            valc_q <= valc_d;
            cnt_q  <= cnt_d;
        end
    end

    // A mispredict squashes the dependent load's consumer anyway, so no stall is needed then.
    assign stall_fd = halted || (load_use && !mispredict);
    assign squash_d = mispredict;

    assign e_stat     = ctrl_q.stat;
    assign e_icode    = ctrl_q.icode;
    assign e_ifun     = ctrl_q.ifun;
    assign e_dstE     = ctrl_q.dst_e;
    assign e_dstM     = ctrl_q.dst_m;
    assign e_valA     = vala_q;
    assign e_valB     = valb_q;
    assign e_valC     = valc_q;
    assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_exec_issue_reg.sv
// Directed bench for exec_issue_reg with a reference model feeding a scoreboard queue.
module tb_exec_issue_reg;

    localparam int DW = 32;
    localparam int CW = 4;

    typedef logic [3+4+4+DW*3+4+4+CW-1:0] exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [2:0]    d_stat;
    logic [3:0]    d_icode, d_ifun, d_dstE, d_dstM, d_srcA, d_srcB;
    logic [DW-1:0] d_valA, d_valB, d_valC;
    logic          e_cond, ext_stall;
    logic [2:0]    e_stat;
    logic [3:0]    e_icode, e_ifun, e_dstE, e_dstM;
    logic [DW-1:0] e_valA, e_valB, e_valC;
    logic          stall_fd, squash_d;
    logic [CW-1:0] bubble_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model of the execute register
    logic [2:0]    m_stat;
    logic [3:0]    m_icode, m_ifun, m_dstE, m_dstM;
    logic [DW-1:0] m_valA, m_valB, m_valC;
    logic [CW-1:0] m_cnt;
    bit            m_valid = 1'b0;

    exp_t sb[$];

    always #5 clk = ~clk;

    exec_issue_reg #(.DATA_WID(DW), .CNT_WID(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .d_stat(d_stat), .d_icode(d_icode), .d_ifun(d_ifun),
        .d_valA(d_valA), .d_valB(d_valB), .d_valC(d_valC),
        .d_dstE(d_dstE), .d_dstM(d_dstM), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .e_cond(e_cond), .ext_stall(ext_stall),
        .e_stat(e_stat), .e_icode(e_icode), .e_ifun(e_ifun),
        .e_valA(e_valA), .e_valB(e_valB), .e_valC(e_valC),
        .e_dstE(e_dstE), .e_dstM(e_dstM),
        .stall_fd(stall_fd), .squash_d(squash_d), .bubble_cnt(bubble_cnt)
    );

    task automatic cyc(input string tag, input logic rn, input logic [2:0] st,
                       input logic [3:0] ic, input logic [3:0] fn,
                       input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c,
                       input logic [3:0] de, input logic [3:0] dm,
                       input logic [3:0] sa, input logic [3:0] sbr,
                       input logic cond, input logic xs);
        logic lu, mp, ex_stall, ex_squash;
        exp_t got, want;
        rst_n = rn; d_stat = st; d_icode = ic; d_ifun = fn;
        d_valA = a; d_valB = b; d_valC = c; d_dstE = de; d_dstM = dm;
        d_srcA = sa; d_srcB = sbr; e_cond = cond; ext_stall = xs;
        #1;
        if (m_valid) begin
            lu = ((m_icode == 4'h5) || (m_icode == 4'hB)) && (m_dstM != 4'hF) &&
                 ((m_dstM == sa) || (m_dstM == sbr));
            mp = (m_icode == 4'h7) && !cond;
            ex_stall  = (m_stat != 3'd1) || (lu && !mp);
            ex_squash = mp;
            total++;
            assert (stall_fd === ex_stall) else begin
                bad++;
                $error("FAIL %s stall_fd observed=%b expected=%b", tag, stall_fd, ex_stall);
            end
            total++;
            assert (squash_d === ex_squash) else begin
                bad++;
                $error("FAIL %s squash_d observed=%b expected=%b", tag, squash_d, ex_squash);
            end
        end else begin
            lu = 1'b0;
            mp = 1'b0;
        end
        if (!rn) begin
            m_stat = 3'd1; m_icode = 4'h1; m_ifun = 4'h0;
            m_valA = '0; m_valB = '0; m_valC = '0;
            m_dstE = 4'hF; m_dstM = 4'hF; m_cnt = '0;
            m_valid = 1'b1;
        end else if (xs || m_stat != 3'd1) begin
            // hold
        end else if (mp || lu) begin
            m_stat = 3'd1; m_icode = 4'h1; m_ifun = 4'h0;
            m_valA = '0; m_valB = '0; m_valC = '0;
            m_dstE = 4'hF; m_dstM = 4'hF;
            if (m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
        end else begin
            m_stat = st; m_icode = ic; m_ifun = fn;
            m_valA = a; m_valB = b; m_valC = c; m_dstE = de; m_dstM = dm;
        end
        sb.push_back({m_stat, m_icode, m_ifun, m_valA, m_valB, m_valC, m_dstE, m_dstM, m_cnt});
        @(posedge clk);
        #1;
        got = {e_stat, e_icode, e_ifun, e_valA, e_valB, e_valC, e_dstE, e_dstM, bubble_cnt};
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL %s scoreboard empty observed=%h expected=entry", tag, got);
        end else begin
            want = sb.pop_front();
            assert (got === want) else begin
                bad++;
                $error("FAIL %s e_state observed=%h expected=%h", tag, got, want);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; d_stat = 3'd1; d_icode = 4'h1; d_ifun = 4'h0;
        d_valA = '0; d_valB = '0; d_valC = '0; d_dstE = 4'hF; d_dstM = 4'hF;
        d_srcA = 4'hF; d_srcB = 4'hF; e_cond = 1'b1; ext_stall = 1'b0;
        @(negedge clk);

        // Reset two cycles, then IRMOVL $0x10, %r0
        cyc("rst0", 1'b0, 3'd1, 4'h3, 4'h0, 0, 0, 32'h10, 4'h0, 4'hF, 4'hF, 4'hF, 1'b1, 1'b0);
        cyc("rst1", 1'b0, 3'd1, 4'h3, 4'h0, 0, 0, 32'h10, 4'h0, 4'hF, 4'hF, 4'hF, 1'b1, 1'b0);
        cyc("irmovl", 1'b1, 3'd1, 4'h3, 4'h0, 0, 0, 32'h10, 4'h0, 4'hF, 4'hF, 4'hF, 1'b1, 1'b0);

        // Load/use: MRMOVL -> r3, then OPL reading r3
        cyc("mrmovl", 1'b1, 3'd1, 4'h5, 4'h0, 0, 32'h100, 32'h4, 4'hF, 4'h3, 4'h1, 4'h2, 1'b1, 1'b0);
        cyc("lu_stall", 1'b1, 3'd1, 4'h6, 4'h0, 32'h7, 32'h8, 0, 4'h3, 4'hF, 4'h3, 4'h4, 1'b1, 1'b0);
        cyc("lu_issue", 1'b1, 3'd1, 4'h6, 4'h0, 32'h7, 32'h8, 0, 4'h3, 4'hF, 4'h3, 4'h4, 1'b1, 1'b0);
        // srcB match with POPL, and RNONE source must not match RNONE-free loads
        cyc("popl", 1'b1, 3'd1, 4'hB, 4'h0, 0, 32'h200, 0, 4'h4, 4'h6, 4'h4, 4'h4, 1'b1, 1'b0);
        cyc("lu_srcb", 1'b1, 3'd1, 4'h2, 4'h0, 32'h1, 0, 0, 4'h5, 4'hF, 4'hF, 4'h6, 1'b1, 1'b0);
        cyc("lu_srcb2", 1'b1, 3'd1, 4'h2, 4'h0, 32'h1, 0, 0, 4'h5, 4'hF, 4'hF, 4'h6, 1'b1, 1'b0);

        // Mispredict: JXX in E with cond=0 while D holds a load
        cyc("jxx", 1'b1, 3'd1, 4'h7, 4'h1, 0, 0, 32'h40, 4'hF, 4'hF, 4'hF, 4'hF, 1'b1, 1'b0);
        cyc("mispred", 1'b1, 3'd1, 4'h5, 4'h0, 0, 32'h8, 0, 4'hF, 4'h2, 4'h1, 4'hF, 1'b0, 1'b0);
        cyc("jxx_t", 1'b1, 3'd1, 4'h7, 4'h0, 0, 0, 32'h80, 4'hF, 4'hF, 4'hF, 4'hF, 1'b1, 1'b0);
        cyc("taken", 1'b1, 3'd1, 4'h6, 4'h1, 32'h3, 32'h4, 0, 4'h2, 4'hF, 4'h0, 4'h1, 1'b1, 1'b0);

        // ext_stall with OPL valA=5 in E for three cycles
        cyc("opl5", 1'b1, 3'd1, 4'h6, 4'h0, 32'h5, 32'h6, 0, 4'h1, 4'hF, 4'h2, 4'h3, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc("xstall", 1'b1, 3'd1, 4'(i + 2), 4'(i), $urandom, $urandom, $urandom,
                4'(i), 4'hF, 4'hE, 4'hE, 1'b1, 1'b1);
        end
        cyc("xs_rel", 1'b1, 3'd1, 4'h2, 4'h0, 32'hAB, 0, 0, 4'h7, 4'hF, 4'h1, 4'hF, 1'b1, 1'b0);

        // ext_stall during a mispredict holds; the mispredict acts on release
        cyc("jxx2", 1'b1, 3'd1, 4'h7, 4'h2, 0, 0, 32'h90, 4'hF, 4'hF, 4'hF, 4'hF, 1'b1, 1'b0);
        cyc("mp_xs", 1'b1, 3'd1, 4'h2, 4'h0, 32'h1, 0, 0, 4'h1, 4'hF, 4'h0, 4'hF, 1'b0, 1'b1);
        cyc("mp_rel", 1'b1, 3'd1, 4'h2, 4'h0, 32'h1, 0, 0, 4'h1, 4'hF, 4'h0, 4'hF, 1'b0, 1'b0);

        // Halt freeze
        cyc("hlt", 1'b1, 3'd2, 4'h0, 4'h0, 0, 0, 0, 4'hF, 4'hF, 4'hF, 4'hF, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc("frozen", 1'b1, 3'd1, 4'($urandom_range(1, 11)), 4'($urandom), $urandom, $urandom,
                $urandom, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                1'($urandom), 1'b0);
        end
        cyc("hlt_rst", 1'b0, 3'd1, 4'h1, 4'h0, 0, 0, 0, 4'hF, 4'hF, 4'hF, 4'hF, 1'b1, 1'b0);

        // Saturation: 20 mispredicts on a 4-bit counter
        for (int i = 0; i < 20; i++) begin
            cyc("sat_jxx", 1'b1, 3'd1, 4'h7, 4'h3, 0, 0, 32'(i), 4'hF, 4'hF, 4'hF, 4'hF, 1'b1, 1'b0);
            cyc("sat_mp", 1'b1, 3'd1, 4'h6, 4'h0, 32'(i), 0, 0, 4'h0, 4'hF, 4'h1, 4'h2, 1'b0, 1'b0);
        end
        total++;
        assert (bubble_cnt === 4'hF) else begin
            bad++;
            $error("FAIL sat_final bubble_cnt observed=%h expected=f", bubble_cnt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
